// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder memory model.
// Used by mem_responder and mem_array; no configuration macros live here.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  localparam int LINE_BYTES       = 16;
  localparam int LINE_OFFSET_BITS = $clog2(LINE_BYTES);

  // The counter is loaded with LATENCY-LATENCY_MIN, so it must cover LATENCY_MAX-LATENCY_MIN.
  localparam int LATENCY_MIN = 2;
  localparam int LATENCY_MAX = 15;
  localparam int COUNT_WIDTH = $clog2(LATENCY_MAX);

  function automatic req_id_t other_port(input req_id_t id);
    return (id == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Line storage for mem_responder: one synchronous read/write port, read-first,
// registered read data and deliberately no reset so contents survive reset.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int LINE_SIZE   = 128,
  parameter int DEPTH       = 256,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clk,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic                   we,
  input  logic [LINE_SIZE-1:0]   wdata,
  output logic [LINE_SIZE-1:0]   rdata
);

  logic [LINE_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
    rdata <= mem[index];
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency line-fill memory shared by an I-cache and a D-cache port.
// Define MEM_ROUND_ROBIN_EN to arbitrate collisions round-robin instead of D-over-I.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDRESS_SIZE = 32,
  parameter int LINE_SIZE    = 128,
  parameter int MEM_SIZE     = 32'h1000,
  parameter int LATENCY      = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    I_req,
  input  logic [ADDRESS_SIZE-1:0] I_addr,
  output logic                    I_ack,
  output logic [LINE_SIZE-1:0]    I_line,
  input  logic                    D_req,
  input  logic                    D_we,
  input  logic [ADDRESS_SIZE-1:0] D_addr,
  input  logic [LINE_SIZE-1:0]    D_wline,
  output logic                    D_ack,
  output logic [LINE_SIZE-1:0]    D_line
);

  localparam int DEPTH       = MEM_SIZE / LINE_BYTES;
  localparam int INDEX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_LOAD = COUNT_WIDTH'(LATENCY - LATENCY_MIN);

  state_t                   state_reg, state_next;
  logic [COUNT_WIDTH-1:0]   count_reg, count_next;
  req_id_t                  grant_reg, grant_next;
  logic [INDEX_WIDTH-1:0]   index_reg, index_next;
  logic                     we_reg, we_next;
  logic [LINE_SIZE-1:0]     wline_reg, wline_next;
  logic                     i_ack_reg, i_ack_next;
  logic                     d_ack_reg, d_ack_next;
  logic [LINE_SIZE-1:0]     i_line_reg, i_line_next;
  logic [LINE_SIZE-1:0]     d_line_reg, d_line_next;
  logic                     mem_we;
  logic [LINE_SIZE-1:0]     mem_rdata;
  req_id_t                  arb_grant;

  // Wrap into the backing store first, then drop the byte-within-line bits.
  function automatic logic [INDEX_WIDTH-1:0] line_index(input logic [ADDRESS_SIZE-1:0] addr);
    logic [ADDRESS_SIZE-1:0] wrapped;
    wrapped = addr % ADDRESS_SIZE'(MEM_SIZE);
    return INDEX_WIDTH'(wrapped >> LINE_OFFSET_BITS);
  endfunction

`ifdef MEM_ROUND_ROBIN_EN
  req_id_t last_grant_reg;

  always_comb begin
    arb_grant = REQ_I;
    if (I_req && D_req) begin
      arb_grant = other_port(last_grant_reg);
    end else if (D_req) begin
      arb_grant = REQ_D;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_reg <= REQ_I;
    end else if (state_reg == IDLE && (I_req || D_req)) begin
      last_grant_reg <= arb_grant;
    end
  end
`else
  always_comb begin
    arb_grant = D_req ? REQ_D : REQ_I;
  end
`endif

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    grant_next  = grant_reg;
    index_next  = index_reg;
    we_next     = we_reg;
    wline_next  = wline_reg;
    i_ack_next  = 1'b0;
    d_ack_next  = 1'b0;
    i_line_next = '0;
    d_line_next = '0;
    mem_we      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (I_req || D_req) begin
          grant_next = arb_grant;
          count_next = COUNT_LOAD;
          state_next = BUSY;
          if (arb_grant == REQ_D) begin
            index_next = line_index(D_addr);
            we_next    = D_we;
            wline_next = D_wline;
          end else begin
            index_next = line_index(I_addr);
            we_next    = 1'b0;
          end
        end
      end

      BUSY: begin
        if (count_reg == '0) begin
          state_next = RESP;
        end else begin
          count_next = count_reg - COUNT_WIDTH'(1);
        end
      end

      // Write commits on this edge; a write echoes the stored line instead of the stale read.
      RESP: begin
        mem_we     = we_reg;
        state_next = GAP;
        if (grant_reg == REQ_D) begin
          d_ack_next  = 1'b1;
          d_line_next = we_reg ? wline_reg : mem_rdata;
        end else begin
          i_ack_next  = 1'b1;
          i_line_next = mem_rdata;
        end
      end

      GAP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      grant_reg  <= REQ_I;
      index_reg  <= '0;
      we_reg     <= 1'b0;
      wline_reg  <= '0;
      i_ack_reg  <= 1'b0;
      d_ack_reg  <= 1'b0;
      i_line_reg <= '0;
      d_line_reg <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      grant_reg  <= grant_next;
      index_reg  <= index_next;
      we_reg     <= we_next;
      wline_reg  <= wline_next;
      i_ack_reg  <= i_ack_next;
      d_ack_reg  <= d_ack_next;
      i_line_reg <= i_line_next;
      d_line_reg <= d_line_next;
    end
  end

  mem_array #(
    .LINE_SIZE  (LINE_SIZE),
    .DEPTH      (DEPTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_mem (
    .clk  (clk),
    .index(index_reg),
    .we   (mem_we),
    .wdata(wline_reg),
    .rdata(mem_rdata)
  );

  assign I_ack  = i_ack_reg;
  assign D_ack  = d_ack_reg;
  assign I_line = i_line_reg;
  assign D_line = d_line_reg;

endmodule
